// File: rtl/li_pkg.sv
// Shared constants and types for the load-immediate expander.
// Opcodes, extender-mode codes, classifier kinds and FSM states live here
// so the classifier, the expander and any future consumers agree on them.
package li_pkg;

  // I-type major opcodes emitted by the expander
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Immediate-extender mode applied by the datapath to each emitted word
  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;

  // Shortest instruction sequence able to materialise a constant
  typedef enum logic [1:0] {
    KIND_ADDIU = 2'd0,  // one addiu, sign-extended low half
    KIND_ORI   = 2'd1,  // one ori, zero-extended low half
    KIND_LUI   = 2'd2,  // one lui, low half is zero
    KIND_PAIR  = 2'd3   // lui then ori
  } kind_e;

  // Output-side FSM: what, if anything, is currently held on out_*
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // nothing held
    S_ONE    = 2'd1,  // single-word request held, last=1
    S_FIRST  = 2'd2,  // lui of a pair held, ori still pending
    S_SECOND = 2'd3   // ori of a pair held, last=1
  } state_e;

  // Pack an I-type instruction word
  function automatic logic [31:0] enc_itype(input logic [5:0]  op,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/li_expander_if.sv
// Request/response bundle of the load-immediate expander.
// master = test-program generator plus instruction-memory consumer side,
// slave  = the expander itself.
interface li_expander_if;

  // request side: constant plus destination register
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;

  // response side: one encoded instruction word per handshake
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_eop;
  logic        out_last;

  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_instr, out_eop, out_last
  );

  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_instr, out_eop, out_last
  );

endinterface

// File: rtl/li_classify.sv
// Classifies a 32-bit constant into the shortest load sequence.
// Latency: purely combinational. Backpressure: none, no state.
// ADDIU_SHORT_EN enables the single-addiu form for signed 16-bit values.
module li_classify
  import li_pkg::*;
(
  input  logic [31:0] value_i,
  output kind_e       kind_o,
  output logic [15:0] hi16_o,
  output logic [15:0] lo16_o
);

  assign hi16_o = value_i[31:16];
  assign lo16_o = value_i[15:0];

  // Lower-priority rules first, the addiu rule overrides them when enabled
  always_comb begin
    kind_o = KIND_PAIR;
    if (value_i[31:16] == 16'h0000) begin
      kind_o = KIND_ORI;
    end else if (value_i[15:0] == 16'h0000) begin
      kind_o = KIND_LUI;
    end
`ifdef ADDIU_SHORT_EN
    // upper 17 bits all equal: the value fits a sign-extended 16-bit imm
    if (value_i[31:15] == {17{value_i[15]}}) begin
      kind_o = KIND_ADDIU;
    end
`endif
  end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: constant + rt -> one or two I-type words tagged with extender mode.
// Latency: request accepted at edge N presents its first word from N+1; pairs add one word.
// Backpressure: held word frozen while !out_ready; in_ready only when idle or the last word retires.
// Optional feature: define ADDIU_SHORT_EN to emit a single addiu for signed 16-bit constants.
module li_expander
  import li_pkg::*;
(
  input logic          clk,
  input logic          reset,
  li_expander_if.slave bus
);

  // output-side state and the held word
  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  eop_q,   eop_d;
  logic        last_q,  last_d;

  // remembered operands for the ori half of a lui+ori pair
  logic [4:0]  rt_q, rt_d;
  logic [15:0] lo_q, lo_d;

  // classifier results for the request currently offered
  kind_e       kind;
  logic [15:0] hi16;
  logic [15:0] lo16;

  logic        out_vld;
  logic        out_hs;
  logic        in_rdy;
  logic        accept;

  li_classify u_classify (
    .value_i (bus.in_value),
    .kind_o  (kind),
    .hi16_o  (hi16),
    .lo16_o  (lo16)
  );

  // A word is held in every state except IDLE; out_* come straight from
  // registers so nothing on the request side reaches them combinationally.
  assign out_vld = (state_q != S_IDLE);
  assign out_hs  = out_vld && bus.out_ready;

  // A new request may enter when nothing is held, or when the final word of
  // the current request leaves this very cycle. Held low throughout reset.
  assign in_rdy  = reset && ((state_q == S_IDLE) || (out_vld && last_q && bus.out_ready));
  assign accept  = bus.in_valid && in_rdy;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_instr = instr_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_last  = last_q;

  // Next state: retire the presented word, then load a newly accepted request
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    eop_d   = eop_q;
    last_d  = last_q;
    rt_d    = rt_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
      end
      S_FIRST: begin
        // lui taken: follow with ori rt,rt,lo to fill the low half
        if (out_hs) begin
          state_d = S_SECOND;
          instr_d = enc_itype(OP_ORI, rt_q, rt_q, lo_q);
          eop_d   = EOP_ZERO;
          last_d  = 1'b1;
        end
      end
      S_ONE, S_SECOND: begin
        // final word taken: go empty unless a request is loaded below
        if (out_hs) begin
          state_d = S_IDLE;
          instr_d = '0;
          eop_d   = EOP_SIGN;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // accept implies the output register is free (idle or last word leaving)
    if (accept) begin
      rt_d = bus.in_rt;
      lo_d = lo16;
      case (kind)
        KIND_ADDIU: begin
          state_d = S_ONE;
          instr_d = enc_itype(OP_ADDIU, 5'd0, bus.in_rt, lo16);
          eop_d   = EOP_SIGN;
          last_d  = 1'b1;
        end
        KIND_ORI: begin
          state_d = S_ONE;
          instr_d = enc_itype(OP_ORI, 5'd0, bus.in_rt, lo16);
          eop_d   = EOP_ZERO;
          last_d  = 1'b1;
        end
        KIND_LUI: begin
          state_d = S_ONE;
          instr_d = enc_itype(OP_LUI, 5'd0, bus.in_rt, hi16);
          eop_d   = EOP_LUI;
          last_d  = 1'b1;
        end
        default: begin
          // KIND_PAIR: lui first, ori comes from rt_q/lo_q afterwards
          state_d = S_FIRST;
          instr_d = enc_itype(OP_LUI, 5'd0, bus.in_rt, hi16);
          eop_d   = EOP_LUI;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // State register; reset drops any held word, including a half-sent pair
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      eop_q   <= EOP_SIGN;
      last_q  <= 1'b0;
      rt_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      rt_q    <= rt_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench for li_expander: a driver pushes expected words when a
// request is accepted, a monitor pops and compares on each output handshake.
// Expected words for directed cases are literal; random cases use a model.
module tb_li_expander;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  eop;
    logic        last;
  } exp_word_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  li_expander_if bus_if ();

  li_expander dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  exp_word_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pick the shortest sequence from the value's numeric range
  function automatic int model(input logic [31:0] v, input logic [4:0] rt,
                               output exp_word_t w0, output exp_word_t w1);
    logic [31:0] hi, lo, rt_f, rs_f;
    hi   = v / 32'd65536;
    lo   = v % 32'd65536;
    rt_f = 32'(rt) * 32'd65536;     // rt field, bits 20:16
    rs_f = 32'(rt) * 32'd2097152;   // rs field, bits 25:21
    w1   = '0;
`ifdef ADDIU_SHORT_EN
    begin : short_rule
      int s;
      s = $signed(v);
      if (s >= -32768 && s <= 32767) begin
        w0 = '{32'h2400_0000 + rt_f + lo, 2'b00, 1'b1};
        return 1;
      end
    end
`endif
    if (v < 32'd65536) begin
      w0 = '{32'h3400_0000 + rt_f + lo, 2'b01, 1'b1};
      return 1;
    end
    if (lo == 32'd0) begin
      w0 = '{32'h3C00_0000 + rt_f + hi, 2'b10, 1'b1};
      return 1;
    end
    w0 = '{32'h3C00_0000 + rt_f + hi, 2'b10, 1'b0};
    w1 = '{32'h3400_0000 + rs_f + rt_f + lo, 2'b01, 1'b1};
    return 2;
  endfunction

  // Offer one request until accepted; out_ready is 1 with probability pct%
  task automatic send_req(input logic [31:0] v, input logic [4:0] rt, input int pct,
                          input exp_word_t w0, input exp_word_t w1, input int n);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.in_value  = v;
      bus_if.in_rt     = rt;
      bus_if.out_ready = ($urandom_range(99) < pct);
      #3;
      if (bus_if.in_ready) begin
        sb_q.push_back(w0);
        if (n == 2) sb_q.push_back(w1);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: value %h never accepted", v);
    end
  endtask

  task automatic send_model(input logic [31:0] v, input logic [4:0] rt, input int pct);
    exp_word_t w0, w1;
    int n;
    n = model(v, rt, w0, w1);
    send_req(v, rt, pct, w0, w1, n);
  endtask

  task automatic idle(input int cycles, input int pct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus_if.in_valid  = 1'b0;
      bus_if.in_value  = $urandom;
      bus_if.in_rt     = 5'($urandom_range(31));
      bus_if.out_ready = ($urandom_range(99) < pct);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) idle(1, 100);
    idle(1, 100);
  endtask

  // Monitor: protocol checks, then pop-and-compare on each output handshake
  initial begin
    exp_word_t w;
    exp_word_t held;
    bit prev_hold;
    bit post_rst;
    logic exp_ir;
    prev_hold = 1'b0;
    post_rst  = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("in_ready_in_reset", 32'(bus_if.in_ready), 32'd0);
        prev_hold = 1'b0;
        post_rst  = 1'b1;
        #1;
        sb_q.delete();
        continue;
      end
      if (post_rst) begin
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_instr", bus_if.out_instr, 32'd0);
        check("rst_out_eop", 32'(bus_if.out_eop), 32'd0);
        check("rst_out_last", 32'(bus_if.out_last), 32'd0);
        post_rst = 1'b0;
      end
      if (prev_hold) begin
        check("hold_valid", 32'(bus_if.out_valid), 32'd1);
        check("hold_instr", bus_if.out_instr, held.instr);
        check("hold_eop_last", {29'd0, bus_if.out_eop, bus_if.out_last}, {29'd0, held.eop, held.last});
      end
      check("out_valid", 32'(bus_if.out_valid), 32'(sb_q.size() != 0));
      exp_ir = (sb_q.size() == 0) || (sb_q.size() == 1 && bus_if.out_ready);
      check("in_ready", 32'(bus_if.in_ready), 32'(exp_ir));
      #1;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, expected no output", bus_if.out_instr);
        end else begin
          w = sb_q.pop_front();
          check("out_instr", bus_if.out_instr, w.instr);
          check("out_eop", 32'(bus_if.out_eop), 32'(w.eop));
          check("out_last", 32'(bus_if.out_last), 32'(w.last));
        end
      end
      prev_hold = bus_if.out_valid && !bus_if.out_ready;
      held      = '{bus_if.out_instr, bus_if.out_eop, bus_if.out_last};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed cases from the plan, then randomized traffic
  initial begin
    logic [31:0] corner [8];
    logic [31:0] v;
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_7FFF;
    corner[2] = 32'h0000_8000; corner[3] = 32'h0000_FFFF;
    corner[4] = 32'h0001_0000; corner[5] = 32'hFFFF_7FFF;
    corner[6] = 32'hFFFF_8000; corner[7] = 32'h8000_0000;

    bus_if.in_valid  = 1'b0;
    bus_if.in_value  = '0;
    bus_if.in_rt     = '0;
    bus_if.out_ready = 1'b0;
    reset            = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

`ifdef ADDIU_SHORT_EN
    send_req(32'hFFFF_8000, 5'd8, 100, '{32'h2408_8000, 2'b00, 1'b1}, '0, 1);
    drain();
    send_req(32'hFFFF_FFFF, 5'd3, 100, '{32'h2403_FFFF, 2'b00, 1'b1}, '0, 1);
`else
    send_req(32'hFFFF_8000, 5'd8, 100, '{32'h3C08_FFFF, 2'b10, 1'b0}, '{32'h3508_8000, 2'b01, 1'b1}, 2);
    drain();
    send_req(32'hFFFF_FFFF, 5'd3, 100, '{32'h3C03_FFFF, 2'b10, 1'b0}, '{32'h3463_FFFF, 2'b01, 1'b1}, 2);
`endif
    drain();
    send_req(32'h0000_8000, 5'd9, 100, '{32'h3409_8000, 2'b01, 1'b1}, '0, 1);
    send_req(32'h1234_0000, 5'd2, 100, '{32'h3C02_1234, 2'b10, 1'b1}, '0, 1);
    drain();

    // pair with out_ready low for three cycles: lui held stable, in_ready low
    send_req(32'h1234_5678, 5'd4, 0, '{32'h3C04_1234, 2'b10, 1'b0}, '{32'h3484_5678, 2'b01, 1'b1}, 2);
    idle(3, 0);
    idle(3, 100);
    drain();

    // back-to-back singles with out_ready held high: one word per cycle
    for (int i = 0; i < 6; i++) send_model(32'($urandom_range(65535)), 5'($urandom_range(31)), 100);
    drain();

    // reset one cycle after the lui of a pair is taken: ori must never appear
    send_req(32'hABCD_1234, 5'd5, 100, '{32'h3C05_ABCD, 2'b10, 1'b0}, '{32'h34A5_1234, 2'b01, 1'b1}, 2);
    idle(1, 100);
    do_reset();
    send_req(32'h0000_8000, 5'd9, 100, '{32'h3409_8000, 2'b01, 1'b1}, '0, 1);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(5))
        0: v = 32'($urandom_range(65535));
        1: v = 32'hFFFF_0000 | 32'($urandom_range(65535));
        2: v = $urandom << 16;
        3: v = corner[$urandom_range(7)];
        default: v = $urandom;
      endcase
      send_model(v, 5'($urandom_range(31)), 70);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3), 60);
    end
    drain();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
